// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: game-logic write handshake plus
// the single-port frame-buffer RAM bus.
interface vram_arbiter_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  ram_rdata,
    output wr_ready,
    output ram_addr,
    output ram_we,
    output ram_wdata
  );

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output ram_rdata,
    input  wr_ready,
    input  ram_addr,
    input  ram_we,
    input  ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one frame-buffer RAM between
// scan-out reads, clear-screen fills and queued writes.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CELLS      = 19200
) (
  input  logic          clk25,
  input  logic          resetn,
  input  logic          active,
  input  logic          hSync,
  input  logic          vSync,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          clear_start,
  input  logic [7:0]    clear_color,
  output logic          clear_busy,
  output logic [7:0]    color,
  output logic          hSync_o,
  output logic          vSync_o,
  output logic          active_o,
  vram_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST = 15'(CELLS - 1);
  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clr_state_t;

  clr_state_t  r_state;
  clr_state_t  w_state_nxt;

  logic [14:0] r_cnt;
  logic [7:0]  r_clr_color;
  logic [14:0] r_fa [FIFO_DEPTH];
  logic [7:0]  r_fd [FIFO_DEPTH];
  logic [PW:0] r_wptr;
  logic [PW:0] r_rptr;
  logic [14:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_scan_d;
  logic [7:0]  r_pix;
  logic [1:0]  r_hs;
  logic [1:0]  r_vs;
  logic [1:0]  r_act;

  logic        w_scan;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_clr_wr;
  logic        w_we;
  logic [14:0] w_yb;
  logic [14:0] w_xb;
  logic [14:0] w_scan_addr;
  logic [14:0] w_addr;
  logic [7:0]  w_wdata;

  // 4x4 screen blocks: (y/4)*160 + x/4 as shifts
  assign w_yb = {7'd0, pixel_y[9:2]};
  assign w_xb = {7'd0, pixel_x[9:2]};
  assign w_scan_addr = (w_yb << 7) + (w_yb << 5) + w_xb;

  // the bus stays quiet while reset is held
  assign w_scan = resetn & active & (pixel_x[1:0] == 2'b00);

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push  = bus.wr_valid & ~w_full;

  // slot arbitration: scan, then clear, then fifo
  always_comb begin
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_we     = 1'b0;
    w_pop    = 1'b0;
    w_clr_wr = 1'b0;
    if (w_scan) begin
      w_addr = w_scan_addr;
    end else if (r_state == S_CLEAR) begin
      w_addr   = r_cnt;
      w_wdata  = r_clr_color;
      w_we     = 1'b1;
      w_clr_wr = 1'b1;
    end else if (!w_empty) begin
      w_addr  = r_fa[r_rptr[PW-1:0]];
      w_wdata = r_fd[r_rptr[PW-1:0]];
      w_we    = 1'b1;
      w_pop   = 1'b1;
    end
  end

  // clear sequencer next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (clear_start) w_state_nxt = S_CLEAR;
      S_CLEAR:
        if (w_clr_wr && r_cnt == LAST)
          w_state_nxt = S_IDLE;
    endcase
  end

  // clear state, counter and latched colour
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_clr_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && clear_start) begin
        r_cnt       <= '0;
        r_clr_color <= clear_color;
      end else if (w_clr_wr) begin
        r_cnt <= r_cnt + 15'd1;
      end
    end
  end

  // fifo pointers
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ONE;
      if (w_pop)  r_rptr <= r_rptr + ONE;
    end
  end

  // fifo storage needs no reset
  always_ff @(posedge clk25) begin
    if (w_push) begin
      r_fa[r_wptr[PW-1:0]] <= bus.wr_addr;
      r_fd[r_wptr[PW-1:0]] <= bus.wr_data;
    end
  end

  // last bus address/data, held through idle slots
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  // scan-out capture and sync alignment
  always_ff @(posedge clk25 or negedge resetn) begin
    if (!resetn) begin
      r_scan_d <= 1'b0;
      r_pix    <= '0;
      r_hs     <= 2'b11;
      r_vs     <= 2'b11;
      r_act    <= 2'b00;
    end else begin
      r_scan_d <= w_scan;
      if (r_scan_d) r_pix <= bus.ram_rdata;
      r_hs  <= {r_hs[0], hSync};
      r_vs  <= {r_vs[0], vSync};
      r_act <= {r_act[0], active};
    end
  end

  assign bus.ram_addr  = w_addr;
  assign bus.ram_we    = w_we;
  assign bus.ram_wdata = w_wdata;
  assign bus.wr_ready  = ~w_full;
  assign clear_busy    = (r_state == S_CLEAR);
  assign hSync_o       = r_hs[1];
  assign vSync_o       = r_vs[1];
  assign active_o      = r_act[1];
  assign color         = active_o ? r_pix : 8'h00;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: random raster and writes checked
// against a slot-level reference model and RAM image.
module tb_vram_arbiter;
  localparam int CELLS = 19200;

  logic       clk25 = 1'b0;
  logic       resetn;
  logic       active;
  logic       hSync;
  logic       vSync;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       clear_start;
  logic [7:0] clear_color;
  logic       clear_busy;
  logic [7:0] color;
  logic       hSync_o;
  logic       vSync_o;
  logic       active_o;

  vram_arbiter_if bus();

  vram_arbiter #(
    .FIFO_DEPTH(4),
    .CELLS(CELLS)
  ) dut (
    .clk25(clk25),
    .resetn(resetn),
    .active(active),
    .hSync(hSync),
    .vSync(vSync),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .clear_start(clear_start),
    .clear_color(clear_color),
    .clear_busy(clear_busy),
    .color(color),
    .hSync_o(hSync_o),
    .vSync_o(vSync_o),
    .active_o(active_o),
    .bus(bus)
  );

  always #5 clk25 = ~clk25;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic [7:0] ram_mem [CELLS];
  logic [7:0] ref_mem [CELLS];

  wr_t q[$];
  bit  m_busy;
  int  m_idx;
  int  m_col;
  int  m_last_a;
  bit  m_pv;
  int  m_pd;
  int  m_pix;
  bit  a1, a2, h1, h2, v1, v2;

  int  n_vec;
  int  n_err;
  int  hc, vc, xb, yb;
  bit  blank;

  // synchronous-read frame-buffer RAM
  initial begin
    for (int i = 0; i < CELLS; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[162] = 8'hA5;
    ref_mem[162] = 8'hA5;
    bus.ram_rdata = 8'h00;
    forever begin
      @(posedge clk25);
      if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_wdata;
      bus.ram_rdata <= ram_mem[bus.ram_addr];
    end
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_busy = 0;
    m_idx = 0;
    m_last_a = 0;
    m_pv = 0;
    m_pd = 0;
    m_pix = 0;
    a1 = 0; a2 = 0;
    h1 = 1; h2 = 1;
    v1 = 1; v2 = 1;
  endtask

  task automatic chk_rst(string t);
    chk({t, "_addr"}, 32'(bus.ram_addr), 0);
    chk({t, "_we"}, 32'(bus.ram_we), 0);
    chk({t, "_wdata"}, 32'(bus.ram_wdata), 0);
    chk({t, "_color"}, 32'(color), 0);
    chk({t, "_hs"}, 32'(hSync_o), 1);
    chk({t, "_vs"}, 32'(vSync_o), 1);
    chk({t, "_act"}, 32'(active_o), 0);
    chk({t, "_rdy"}, 32'(bus.wr_ready), 1);
    chk({t, "_busy"}, 32'(clear_busy), 0);
  endtask

  // one clock: check mid-cycle, then advance the model
  task automatic cyc();
    bit scan, ewe, pop, push, clr_wr;
    int ea, ed;
    @(negedge clk25);
    scan = active && (pixel_x % 4 == 0);
    ewe = 0; pop = 0; clr_wr = 0;
    ea = m_last_a; ed = 0;
    if (scan) begin
      ea = int'(pixel_y / 4) * 160 + int'(pixel_x / 4);
    end else if (m_busy) begin
      ea = m_idx; ed = m_col; ewe = 1; clr_wr = 1;
    end else if (q.size() > 0) begin
      ea = q[0].a; ed = q[0].d; ewe = 1; pop = 1;
    end
    chk("ram_we", 32'(bus.ram_we), 32'(ewe));
    chk("ram_addr", 32'(bus.ram_addr), ea);
    if (ewe) chk("ram_wdata", 32'(bus.ram_wdata), ed);
    chk("wr_ready", 32'(bus.wr_ready), 32'(q.size() < 4));
    chk("clear_busy", 32'(clear_busy), 32'(m_busy));
    chk("hSync_o", 32'(hSync_o), 32'(h2));
    chk("vSync_o", 32'(vSync_o), 32'(v2));
    chk("active_o", 32'(active_o), 32'(a2));
    chk("color", 32'(color), a2 ? m_pix : 0);
    push = bus.wr_valid && q.size() < 4;
    if (ewe) ref_mem[ea] = 8'(ed);
    m_last_a = ea;
    if (pop) void'(q.pop_front());
    if (push)
      q.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
    if (clr_wr) begin
      m_idx++;
      if (m_idx == CELLS) m_busy = 0;
    end else if (!m_busy && clear_start) begin
      m_busy = 1; m_idx = 0; m_col = int'(clear_color);
    end
    if (m_pv) m_pix = m_pd;
    m_pv = scan;
    if (scan) m_pd = int'(ref_mem[ea]);
    a2 = a1; a1 = active;
    h2 = h1; h1 = hSync;
    v2 = v1; v1 = vSync;
    @(posedge clk25);
    #1;
  endtask

  // shortened raster: 48-pixel lines, 20-line frames
  task automatic raster();
    hc++;
    if (hc == 48) begin
      hc = 0;
      vc = (vc == 19) ? 0 : vc + 1;
      xb = 4 * int'($urandom_range(0, 152));
      yb = int'($urandom_range(0, 479));
    end
    active  = !blank && hc < 32 && vc < 16;
    pixel_x = 10'(xb + hc);
    pixel_y = 10'(yb);
    hSync   = !(hc >= 36 && hc < 40);
    vSync   = !(vc == 17 || vc == 18);
  endtask

  task automatic run_clear_out();
    int g = 0;
    while (m_busy && g < 40000) begin
      raster(); cyc(); g++;
    end
    chk("clear_timeout", 32'(m_busy), 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    hc = 0; vc = 0; xb = 0; yb = 0; blank = 0;
    resetn = 0; active = 0; hSync = 1; vSync = 1;
    pixel_x = '0; pixel_y = '0;
    clear_start = 0; clear_color = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    m_reset();
    repeat (3) @(posedge clk25);
    #1;
    chk_rst("por");
    resetn = 1;

    active = 1; pixel_y = 10'd5; pixel_x = 10'd8;
    #1;
    chk("t0_addr", 32'(bus.ram_addr), 162);
    chk("t0_we", 32'(bus.ram_we), 0);
    cyc();
    for (int x = 9; x < 16; x++) begin
      pixel_x = 10'(x);
      bus.wr_valid = (x == 12);
      bus.wr_addr = 15'd100;
      bus.wr_data = 8'h3C;
      #1;
      if (x == 10) chk("t2_color", 32'(color), 32'hA5);
      if (x == 13) begin
        chk("t5_color", 32'(color), 32'hA5);
        chk("pri_we", 32'(bus.ram_we), 1);
        chk("pri_addr", 32'(bus.ram_addr), 100);
        chk("pri_wdata", 32'(bus.ram_wdata), 32'h3C);
      end
      cyc();
    end
    active = 0; bus.wr_valid = 0;
    repeat (4) cyc();

    for (int i = 0; i < 3000; i++) begin
      raster();
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_addr = 15'($urandom_range(0, CELLS - 1));
      bus.wr_data = 8'($urandom);
      cyc();
    end
    bus.wr_valid = 0;
    repeat (10) begin raster(); cyc(); end

    clear_start = 1; clear_color = 8'hC3;
    raster(); cyc();
    clear_start = 0;
    for (int k = 0; k < 6; k++) begin
      raster();
      bus.wr_valid = 1;
      bus.wr_addr = 15'($urandom_range(0, CELLS - 1));
      bus.wr_data = 8'(k + 1);
      cyc();
    end
    chk("full_rdy", 32'(bus.wr_ready), 0);
    bus.wr_valid = 0;
    run_clear_out();
    repeat (30) begin raster(); cyc(); end

    blank = 1;
    clear_start = 1; clear_color = 8'h1F;
    raster(); cyc();
    clear_start = 0;
    repeat (1000) begin raster(); cyc(); end
    clear_start = 1; clear_color = 8'h55;
    raster(); cyc();
    clear_start = 0;
    run_clear_out();
    repeat (10) begin raster(); cyc(); end
    for (int i = 0; i < CELLS; i++)
      chk("clear_mem", 32'(ram_mem[i]), 32'h1F);

    blank = 0;
    clear_start = 1; clear_color = 8'h77;
    raster(); cyc();
    clear_start = 0;
    for (int k = 0; k < 3; k++) begin
      raster();
      bus.wr_valid = 1;
      bus.wr_addr = 15'($urandom_range(0, CELLS - 1));
      bus.wr_data = 8'($urandom);
      cyc();
    end
    bus.wr_valid = 0;
    for (int g = 0; g < 2000 && m_idx < 500; g++) begin
      raster(); cyc();
    end
    chk("cnt_500", 32'(m_idx), 500);
    resetn = 0;
    #1;
    chk_rst("arst");
    m_reset();
    repeat (2) @(posedge clk25);
    #1;
    resetn = 1;
    repeat (300) begin raster(); cyc(); end

    for (int i = 0; i < 32; i++) begin
      int c;
      c = int'($urandom_range(0, CELLS - 1));
      chk("ram_image", 32'(ram_mem[c]), 32'(ref_mem[c]));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port, synchronous-read frame-buffer RAM (160x120 cells, 8-bit colour, 19200 words) between display scan-out and game-logic writers. Sits between the 640x480 VGA timing generator and the frame-buffer RAM:
- **Scan-out path:** issues a RAM read every 4th active pixel. Each 4x4 screen block maps to one cell. Presents `color` with syncs delayed to match.
- **Free RAM slots:** shared by a hardware clear-screen sequencer and a 4-deep write FIFO fed by game logic.

## Interface
- `FIFO_DEPTH`, 4, write-FIFO entries (power of two).
- `CELLS`, 19200, frame-buffer words (160x120).

Ports:
- `clk25`  in  1  pixel clock, 25 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `active`  in  1  from timing generator; visible pixel this cycle.
- `hSync`  in  1  horizontal sync from timing generator; active-low.
- `vSync`  in  1  vertical sync from timing generator; active-low.
- `pixel_x`  in  10  from timing generator.
- `pixel_y`  in  10  from timing generator.
- `ram_addr`  out  15  frame-buffer address.
- `ram_we`  out  1  write strobe.
- `ram_wdata`  out  8  write data.
- `ram_rdata`  in  8  read data, valid one cycle after address.
- `wr_valid`  in  1  write request from game logic.
- `wr_addr`  in  15  cell index for the write request.
- `wr_data`  in  8  colour for the write request.
- `wr_ready`  out  1  FIFO can accept; transfer when `wr_valid & wr_ready`.
- `clear_start`  in  1  single-cycle pulse; fill all cells with `clear_color`.
- `clear_color`  in  8  fill colour, sampled with `clear_start`.
- `clear_busy`  out  1  clear in progress.
- `color`  out  8  pixel colour, 0 when not active.
- `hSync_o`  out  1  `hSync` delayed to align with `color`.
- `vSync_o`  out  1  `vSync` delayed to align with `color`.
- `active_o`  out  1  `active` delayed to align with `color`.

## Operation
**Slot classes**, evaluated each cycle in priority order:
- **SCAN:** `active & pixel_x[1:0]==0`. `ram_addr = (pixel_y>>2)*160 + (pixel_x>>2)`, computed as `(y>>2)<<7 + (y>>2)<<5 + (x>>2)`, 15 bits. `ram_we=0`. SCAN always wins.
- **CLEAR:** non-SCAN cycle with `clear_busy=1`. `ram_addr` = clear counter, `ram_we=1`, `ram_wdata` = latched clear colour; counter increments.
- **FIFO:** non-SCAN cycle, `clear_busy=0`, FIFO non-empty. Pop the head: `ram_addr/ram_wdata` from the entry, `ram_we=1`.
- **IDLE:** otherwise. `ram_we=0`, `ram_addr` holds its last value.

**Clear sequencer** (states IDLE, CLEARING):
- IDLE to CLEARING on `clear_start`. Counter←0, latch `clear_color`.
- CLEARING to IDLE in the cycle after the write to address `CELLS-1` is issued.
- `clear_start` while CLEARING is ignored; the latched colour is unchanged.

**Write FIFO:**
- Push on `wr_valid & wr_ready`; `wr_ready = !full`.
- FIFO keeps accepting during a clear but does not drain. Queued writes land after the clear, so draw-after-clear ordering is preserved.
- Simultaneous push and pop when full is not possible (`wr_ready=0`). Push and pop in the same cycle when non-empty leaves occupancy unchanged.

**Scan-out pipeline:**
- T0: SCAN slot issues the address.
- T1: `ram_rdata` valid.
- T2: captured into the pixel register, which holds for 4 pixels.
- `color = active_o ? pixel_reg : 0`.

## Timing
- Scan-out latency is 2 cycles. `hSync_o`, `vSync_o`, `active_o` are `hSync`, `vSync`, `active` through 2 flops.
- A FIFO entry waits at most 1 cycle behind a SCAN slot when no clear is running.
- Clear duration:
  - entirely in blanking: `CELLS` cycles.
  - worst case, all during active video: about 4/3 × `CELLS` cycles.
- `wr_ready` is registered-state-derived (not combinational from `wr_valid`).
- Reset values: `ram_addr=0`, `ram_we=0`, `ram_wdata=0`, `color=0`, `hSync_o=1`, `vSync_o=1`, `active_o=0`, `wr_ready=1`, `clear_busy=0`.
- Reset state: FIFO empty, counter 0, pixel register 0.
- Reset asserted mid-clear aborts the clear and flushes the FIFO; no further writes after release until new requests.

## Test plan
- **Scan-out address and colour:**
  - Stimulus: `active=1`, `pixel_x=8`, `pixel_y=5`.
  - Required: `ram_addr=162` (`(5>>2)*160 + (8>>2) = 160+2`), `ram_we=0`.
  - Required: with `ram_rdata=8'hA5` next cycle, `color=8'hA5` two cycles after T0, held for 4 pixels.
- **Priority between SCAN and FIFO:**
  - Stimulus: push `{addr=100, data=8'h3C}` on a SCAN cycle.
  - Required: write issues on the next non-SCAN cycle with `ram_we=1`, `ram_addr=100`, `ram_wdata=8'h3C`; no write ever coincides with a SCAN slot.
- **FIFO full:**
  - Stimulus: hold `clear_busy=1`, push 4 entries.
  - Required: `wr_ready=0` after the 4th; a 5th `wr_valid` is not accepted.
  - Required: after the clear ends, entries drain in order, one per free cycle.
- **Clear sequence:**
  - Stimulus: `clear_start` with `clear_color=8'h1F` during vertical blanking.
  - Required: writes to 0..19199 with data `8'h1F`; `clear_busy` falls exactly one cycle after the address-19199 write.
  - Required: a second `clear_start` mid-clear has no effect.
- **Sync alignment:**
  - Stimulus: normal frame timing.
  - Required: `hSync_o`, `vSync_o`, `active_o` equal their inputs delayed 2 cycles; `color=0` whenever `active_o=0`.
- **Reset mid-clear:**
  - Stimulus: `resetn=0` at counter=500.
  - Required: all outputs at reset values immediately (asynchronous); after release, `ram_we` stays 0 with no requests.
